// File: rtl/mux4_pkg.sv
// Shared constants and FSM state encoding for the mux4 scan controller.
// Select/data widths are tied to the 4:1 mux and are not meant to be overridden.
package mux4_pkg;

    localparam int SEL_W = 2;
    localparam int DW    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mux4_scan_tick.sv
// DIV prescaler: tick is high on the last clock of each select step.
// Held at zero while clr is high so every scan starts on a fresh step boundary.
module mux4_scan_tick #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr || tick) begin
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Drives a 4:1 mux with a captured word, walks the select 0..3 one step per DIV clocks
// and samples the mux output back into a serial stream, a rebuilt word and an error flag.
module mux4_scan_ctrl
    import mux4_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW-1:0]    din,
    output logic             ready,
    output logic [SEL_W-1:0] a,
    output logic [DW-1:0]    d,
    input  logic             y_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [DW-1:0]    rdata,
    output logic             done,
    output logic             err
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   a_q, a_d;
    logic [DW-1:0]      d_q, d_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               ser_q, ser_d;
    logic               sv_q, sv_d;
    logic               err_q, err_d;
    logic               tick;
    logic               clr;

    assign clr = (state_q != RUN);

    mux4_scan_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        rdata_d = rdata_q;
        ser_d   = ser_q;
        sv_d    = 1'b0;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d     = din;
                    a_d     = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    rdata_d[a_q] = y_in;
                    ser_d        = y_in;
                    sv_d         = 1'b1;
                    // err is judged on the word including the final sample so it is valid alongside done
                    if (a_q == SEL_W'(DW - 1)) begin
                        err_d   = (rdata_d != d_q);
                        state_d = DONE;
                    end else begin
                        a_d = a_q + SEL_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            d_q     <= '0;
            rdata_q <= '0;
            ser_q   <= 1'b0;
            sv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            rdata_q <= rdata_d;
            ser_q   <= ser_d;
            sv_q    <= sv_d;
            err_q   <= err_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign a         = a_q;
    assign d         = d_q;
    assign rdata     = rdata_q;
    assign ser_out   = ser_q;
    assign ser_valid = sv_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: three instances (DIV=1,2,4) each closing the loop through a mux model.
// Expected serial bits and end-of-scan results are queued at acceptance and matched as the DUT emits them.
module tb_mux4_scan_ctrl;

    typedef struct {
        logic val;
        int   k;
    } serEnt_t;

    typedef struct {
        logic [3:0] rdata;
        logic       err;
    } doneEnt_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       faultMode = 1'b0;

    logic       start_s [3];
    logic [3:0] din_s   [3];
    logic       ready_s [3];
    logic [1:0] a_s     [3];
    logic [3:0] d_s     [3];
    logic       y_s     [3];
    logic       ser_s   [3];
    logic       sv_s    [3];
    logic [3:0] rdata_s [3];
    logic       done_s  [3];
    logic       err_s   [3];

    int cyc = 0;
    int sel = 0;
    int startCyc = 0;
    int prevStart = 0;
    int nPass = 0;
    int nTotal = 0;
    bit readyNext = 1'b0;

    serEnt_t  serQ[$];
    doneEnt_t doneQ[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gUnit
        // Behavioural 4:1 mux closing the loop; faultMode models y stuck at 0
        assign y_s[g] = faultMode ? 1'b0 : d_s[g][a_s[g]];

        mux4_scan_ctrl #(
            .DIV (g == 0 ? 1 : (g == 1 ? 2 : 4))
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_s[g]),
            .din       (din_s[g]),
            .ready     (ready_s[g]),
            .a         (a_s[g]),
            .d         (d_s[g]),
            .y_in      (y_s[g]),
            .ser_out   (ser_s[g]),
            .ser_valid (sv_s[g]),
            .rdata     (rdata_s[g]),
            .done      (done_s[g]),
            .err       (err_s[g])
        );
    end

    function automatic int divOf(input int u);
        return (u == 0) ? 1 : ((u == 1) ? 2 : 4);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) begin
            nPass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        nTotal++;
    endtask

    task automatic checkResetValues(input int u, input string pfx);
        checkOutput($sformatf("%s_ready%0d", pfx, u), 32'(ready_s[u]), 32'd1);
        checkOutput($sformatf("%s_a%0d", pfx, u), 32'(a_s[u]), 32'd0);
        checkOutput($sformatf("%s_d%0d", pfx, u), 32'(d_s[u]), 32'd0);
        checkOutput($sformatf("%s_ser%0d", pfx, u), 32'(ser_s[u]), 32'd0);
        checkOutput($sformatf("%s_sv%0d", pfx, u), 32'(sv_s[u]), 32'd0);
        checkOutput($sformatf("%s_rdata%0d", pfx, u), 32'(rdata_s[u]), 32'd0);
        checkOutput($sformatf("%s_done%0d", pfx, u), 32'(done_s[u]), 32'd0);
        checkOutput($sformatf("%s_err%0d", pfx, u), 32'(err_s[u]), 32'd0);
    endtask

    // Raises start, waits for the accepting edge and queues what the scan must produce
    task automatic applyStimulus(input logic [3:0] w, input bit fault);
        int guard;
        doneEnt_t de;
        start_s[sel] = 1'b1;
        din_s[sel]   = w;
        guard = 0;
        while (ready_s[sel] !== 1'b1 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) checkOutput("accept_timeout", 32'd0, 32'd1);
        for (int k = 0; k < 4; k++) begin
            serQ.push_back('{fault ? 1'b0 : w[k], k + 1});
        end
        de.rdata = fault ? 4'h0 : w;
        de.err   = fault ? (w != 4'h0) : 1'b0;
        doneQ.push_back(de);
        @(posedge clk);
        #1;
        prevStart = startCyc;
        startCyc  = cyc;
    endtask

    task automatic waitDone();
        int guard;
        guard = 0;
        while (done_s[sel] !== 1'b1 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) checkOutput("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        serEnt_t  se;
        doneEnt_t de;
        if (readyNext) begin
            checkOutput("ready_after_done", 32'(ready_s[sel]), 32'd1);
            readyNext = 1'b0;
        end
        if (sv_s[sel] === 1'b1) begin
            if (serQ.size() == 0) begin
                checkOutput("spurious_ser_valid", 32'd1, 32'd0);
            end else begin
                se = serQ.pop_front();
                checkOutput("ser_out", 32'(ser_s[sel]), 32'(se.val));
                checkOutput("ser_timing", 32'(cyc - startCyc), 32'(se.k * divOf(sel)));
            end
        end
        if (done_s[sel] === 1'b1) begin
            if (doneQ.size() == 0) begin
                checkOutput("spurious_done", 32'd1, 32'd0);
            end else begin
                de = doneQ.pop_front();
                checkOutput("rdata", 32'(rdata_s[sel]), 32'(de.rdata));
                checkOutput("err", 32'(err_s[sel]), 32'(de.err));
                checkOutput("done_timing", 32'(cyc - startCyc), 32'(4 * divOf(sel)));
                checkOutput("ready_in_done", 32'(ready_s[sel]), 32'd0);
                readyNext = 1'b1;
            end
        end
    end

    initial begin
        int n;
        for (int u = 0; u < 3; u++) begin
            start_s[u] = 1'b0;
            din_s[u]   = 4'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int u = 0; u < 3; u++) checkResetValues(u, "reset");

        $display("[TB] DIV=1 scan of 4'hA");
        sel = 0;
        applyStimulus(4'hA, 1'b0);
        start_s[0] = 1'b0;
        waitDone();

        $display("[TB] DIV=4 scan of 4'h6");
        sel = 2;
        applyStimulus(4'h6, 1'b0);
        start_s[2] = 1'b0;
        waitDone();

        $display("[TB] busy rejection");
        applyStimulus(4'h3, 1'b0);
        start_s[2] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        start_s[2] = 1'b1;
        din_s[2]   = 4'hC;
        @(posedge clk);
        #1;
        start_s[2] = 1'b0;
        checkOutput("busy_d_mid", 32'(d_s[2]), 32'h3);
        n = 0;
        while (done_s[2] !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) checkOutput("busy_done_timeout", 32'd0, 32'd1);
        start_s[2] = 1'b1;
        @(posedge clk);
        #1;
        start_s[2] = 1'b0;
        checkOutput("busy_ready", 32'(ready_s[2]), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("busy_d", 32'(d_s[2]), 32'h3);
        checkOutput("busy_rdata", 32'(rdata_s[2]), 32'h3);

        $display("[TB] fault: y stuck at 0");
        sel = 0;
        faultMode = 1'b1;
        applyStimulus(4'hF, 1'b1);
        start_s[0] = 1'b0;
        waitDone();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("err_held", 32'(err_s[0]), 32'd1);
        faultMode = 1'b0;
        applyStimulus(4'h5, 1'b0);
        start_s[0] = 1'b0;
        checkOutput("err_cleared", 32'(err_s[0]), 32'd0);
        waitDone();

        $display("[TB] reset mid-scan");
        sel = 1;
        applyStimulus(4'hB, 1'b0);
        start_s[1] = 1'b0;
        n = 0;
        for (int i = 0; i < 50 && n < 2; i++) begin
            @(posedge clk);
            #1;
            if (sv_s[1] === 1'b1) n++;
        end
        checkOutput("midscan_sv_count", 32'(n), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        serQ.delete();
        doneQ.delete();
        checkResetValues(1, "midscan");
        repeat (12) @(posedge clk);
        #1;

        $display("[TB] back-to-back with start held");
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'h9, 1'b0);
            if (i > 0) checkOutput("b2b_period", 32'(startCyc - prevStart), 32'(4 * divOf(0) + 2));
        end
        start_s[0] = 1'b0;
        waitDone();
        repeat (3) @(posedge clk);
        #1;

        checkOutput("ser_queue_empty", 32'(serQ.size()), 32'd0);
        checkOutput("done_queue_empty", 32'(doneQ.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
